// File: rtl/conv_window_sequencer.sv
// -----------------------------------------------------------------------------
// conv_window_sequencer
//
// Pops one packed {x,y} event at a time from the event FIFO and checks it
// against the image bounds. For each accepted event it walks the
// KERNEL_SIZE x KERNEL_SIZE neighbourhood, clipped to the image, in row-major
// order. Each in-bounds neighbour is emitted as one valid/ready beat carrying
// the target pixel and its kernel tap indices.
//
// Optional feature: define CONV_DROP_COUNT_EN to add the dropped_count port,
// a saturating 16-bit count of events rejected as out of bounds.
//
// Ports
//   clk            rising-edge clock
//   rst            synchronous, active-high reset
//   enable         permits popping new events
//   fifo_empty     event FIFO empty flag
//   fifo_read_en   one-cycle pop strobe
//   fifo_data      event {x,y}; valid the cycle after fifo_read_en
//   win_valid      beat valid
//   win_ready      downstream accepts beat
//   win_coord      target pixel {x,y}
//   win_kx/win_ky  kernel tap column/row
//   win_last       final beat of the current event
//   busy           sequencer is not idle
//   dropped_count  rejected-event count (CONV_DROP_COUNT_EN only)
// -----------------------------------------------------------------------------
module conv_window_sequencer #(
    parameter int IMG_WIDTH   = 32,
    parameter int IMG_HEIGHT  = 32,
    parameter int COORD_BITS  = 8,
    parameter int KERNEL_SIZE = 3
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           enable,
    input  logic                           fifo_empty,
    output logic                           fifo_read_en,
    input  logic [2*COORD_BITS-1:0]        fifo_data,
    output logic                           win_valid,
    input  logic                           win_ready,
    output logic [2*COORD_BITS-1:0]        win_coord,
    output logic [$clog2(KERNEL_SIZE)-1:0] win_kx,
    output logic [$clog2(KERNEL_SIZE)-1:0] win_ky,
    output logic                           win_last,
    output logic                           busy
`ifdef CONV_DROP_COUNT_EN
    ,
    output logic [15:0]                    dropped_count
`endif
);

    localparam int R  = (KERNEL_SIZE - 1) / 2;
    localparam int SW = COORD_BITS + 2;          // signed width for bound math
    localparam int KW = $clog2(KERNEL_SIZE);

    typedef logic signed [SW-1:0] sword_t;
    typedef logic [COORD_BITS-1:0] coord_t;

    localparam sword_t R_S   = sword_t'(R);
    localparam sword_t X_MAX = sword_t'(IMG_WIDTH - 1);
    localparam sword_t Y_MAX = sword_t'(IMG_HEIGHT - 1);
    localparam sword_t ZERO  = sword_t'(0);

    typedef enum logic [1:0] {
        IDLE,
        READ_REQUEST,
        VALIDATE,
        DATA_READY
    } state_t;

    state_t state, state_next;

    // Event register, clipped window bounds and current tap position.
    coord_t ex, ey;
    coord_t x_lo, x_hi, y_lo, y_hi;
    coord_t tx, ty;

    // ------------------------------------------------------------------
    // Window bounds of the incoming FIFO word (used only in VALIDATE).
    // The two extra sign bits keep ex-R below zero and ex+R past the top
    // of the coordinate range from wrapping.
    // ------------------------------------------------------------------
    coord_t in_x, in_y;
    sword_t in_xs, in_ys;
    sword_t x_lo_s, x_hi_s, y_lo_s, y_hi_s;
    coord_t x_lo_c, x_hi_c, y_lo_c, y_hi_c;
    logic   in_range;

    assign in_x   = fifo_data[2*COORD_BITS-1:COORD_BITS];
    assign in_y   = fifo_data[COORD_BITS-1:0];
    assign in_xs  = sword_t'({2'b00, in_x});
    assign in_ys  = sword_t'({2'b00, in_y});
    assign x_lo_s = in_xs - R_S;
    assign x_hi_s = in_xs + R_S;
    assign y_lo_s = in_ys - R_S;
    assign y_hi_s = in_ys + R_S;

    assign in_range = (in_xs <= X_MAX) && (in_ys <= Y_MAX);

    // NOTE: every always_comb output gets a value on every path (defaults or
    // a full ternary); a path that leaves one unassigned infers a latch.
    always_comb begin
        x_lo_c = (x_lo_s < ZERO)  ? '0 : x_lo_s[COORD_BITS-1:0];
        x_hi_c = (x_hi_s > X_MAX) ? X_MAX[COORD_BITS-1:0] : x_hi_s[COORD_BITS-1:0];
        y_lo_c = (y_lo_s < ZERO)  ? '0 : y_lo_s[COORD_BITS-1:0];
        y_hi_c = (y_hi_s > Y_MAX) ? Y_MAX[COORD_BITS-1:0] : y_hi_s[COORD_BITS-1:0];
    end

    logic at_last;
    assign at_last = (tx == x_hi) && (ty == y_hi);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    // NOTE: clocked blocks use non-blocking assignments only, so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            IDLE:         if (enable && !fifo_empty) state_next = READ_REQUEST;
            READ_REQUEST: state_next = VALIDATE;
            VALIDATE:     state_next = in_range ? DATA_READY : IDLE;
            DATA_READY:   if (win_ready && at_last) state_next = IDLE;
            default:      state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs, decoded from registered state only (no win_ready path)
    // ------------------------------------------------------------------
    always_comb begin
        fifo_read_en = 1'b0;
        win_valid    = 1'b0;
        win_coord    = '0;
        win_kx       = '0;
        win_ky       = '0;
        win_last     = 1'b0;
        busy         = (state != IDLE);
        case (state)
            READ_REQUEST: fifo_read_en = 1'b1;
            DATA_READY: begin
                win_valid = 1'b1;
                win_coord = {tx, ty};
                // tx-ex+R lies in [0, KERNEL_SIZE-1], so modular arithmetic
                // truncated to the tap width gives the exact index.
                win_kx    = KW'(tx - ex + coord_t'(R));
                win_ky    = KW'(ty - ey + coord_t'(R));
                win_last  = at_last;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Event register and tap walker
    // ------------------------------------------------------------------
    // NOTE: the datapath registers are reset along with the FSM so the beat
    // outputs leave reset at zero rather than at a stale coordinate.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex   <= '0;
            ey   <= '0;
            x_lo <= '0;
            x_hi <= '0;
            y_lo <= '0;
            y_hi <= '0;
            tx   <= '0;
            ty   <= '0;
        end else begin
            case (state)
                VALIDATE: begin
                    ex <= in_x;
                    ey <= in_y;
                    if (in_range) begin
                        x_lo <= x_lo_c;
                        x_hi <= x_hi_c;
                        y_lo <= y_lo_c;
                        y_hi <= y_hi_c;
                        tx   <= x_lo_c;
                        ty   <= y_lo_c;
                    end
                end
                DATA_READY: begin
                    // Row-major walk: tx inner, ty outer. After the last beat
                    // ty steps past y_hi, which is harmless because the next
                    // accepted event reloads it.
                    if (win_ready) begin
                        if (tx == x_hi) begin
                            tx <= x_lo;
                            ty <= ty + 1'b1;
                        end else begin
                            tx <= tx + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef CONV_DROP_COUNT_EN
    // Saturating count of events rejected in VALIDATE.
    always_ff @(posedge clk) begin
        if (rst)
            dropped_count <= '0;
        else if (state == VALIDATE && !in_range && dropped_count != 16'hFFFF)
            dropped_count <= dropped_count + 16'd1;
    end
`endif

endmodule

// File: tb/tb_conv_window_sequencer.sv
// -----------------------------------------------------------------------------
// tb_conv_window_sequencer
//
// Self-checking bench for conv_window_sequencer. A queue models the event
// FIFO; each popped event is expanded into its expected list of beats from
// the clipped-window rule. Every cycle the bench checks the pop strobe, busy,
// win_valid, the presented beat, and stability while stalled.
// -----------------------------------------------------------------------------
module tb_conv_window_sequencer;

    localparam int W = 32;
    localparam int H = 32;
    localparam int R = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        fifo_empty;
    logic        fifo_read_en;
    logic [15:0] fifo_data;
    logic        win_valid;
    logic        win_ready;
    logic [15:0] win_coord;
    logic [1:0]  win_kx;
    logic [1:0]  win_ky;
    logic        win_last;
    logic        busy;
`ifdef CONV_DROP_COUNT_EN
    logic [15:0] dropped_count;
`endif

    always #5 clk = ~clk;

    conv_window_sequencer #(
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H),
        .COORD_BITS (8),
        .KERNEL_SIZE(3)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .fifo_empty   (fifo_empty),
        .fifo_read_en (fifo_read_en),
        .fifo_data    (fifo_data),
        .win_valid    (win_valid),
        .win_ready    (win_ready),
        .win_coord    (win_coord),
        .win_kx       (win_kx),
        .win_ky       (win_ky),
        .win_last     (win_last),
        .busy         (busy)
`ifdef CONV_DROP_COUNT_EN
        ,
        .dropped_count(dropped_count)
`endif
    );

    typedef struct packed {
        logic [7:0] x;
        logic [7:0] y;
        logic [1:0] kx;
        logic [1:0] ky;
        logic       last;
    } beat_t;

    beat_t       exp_q[$];
    logic [15:0] fifo_q[$];

    int  total = 0;
    int  bad   = 0;
    int  cyc   = 0;
    int  rd_cyc = -100;      // cycle the DUT last strobed fifo_read_en
    int  drop_at = -1;       // cycle at which dropped_count should step
    int  drop_exp = 0;
    int  ready_mode = 0;     // 0 always, 1 alternate, 2 random, 3 never
    bit  can_pop = 1'b0;     // model: fifo_read_en expected next cycle
    bit  busy_exp = 1'b0;
    bit  rst_req = 1'b0;
    bit  en_req = 1'b0;
    bit  alt = 1'b0;
    bit  pend_pop = 1'b0;
    logic [15:0] pend_data;
    bit  prev_stall = 1'b0;
    logic [15:0] prev_coord;
    logic [1:0]  prev_kx, prev_ky;
    logic        prev_last;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    // Expand one event into the beats the spec requires; returns 0 if the
    // event lies outside the image.
    function automatic bit expand(input logic [15:0] ev);
        int ex = int'(ev[15:8]);
        int ey = int'(ev[7:0]);
        int xlo, xhi, ylo, yhi;
        beat_t b;
        if (ex >= W || ey >= H) return 1'b0;
        xlo = (ex - R < 0) ? 0 : ex - R;
        xhi = (ex + R > W - 1) ? W - 1 : ex + R;
        ylo = (ey - R < 0) ? 0 : ey - R;
        yhi = (ey + R > H - 1) ? H - 1 : ey + R;
        for (int y = ylo; y <= yhi; y++) begin
            for (int x = xlo; x <= xhi; x++) begin
                b.x    = 8'(x);
                b.y    = 8'(y);
                b.kx   = 2'(x - ex + R);
                b.ky   = 2'(y - ey + R);
                b.last = (x == xhi) && (y == yhi);
                exp_q.push_back(b);
            end
        end
        return 1'b1;
    endfunction

    // One clock cycle: apply inputs for the new cycle, then check it.
    task automatic step();
        bit r_prev = rst;
        logic [15:0] ev;
        beat_t h;
        @(posedge clk);
        #1;
        cyc++;
        if (r_prev) begin
            exp_q.delete();
            rd_cyc     = -100;
            pend_pop   = 1'b0;
            drop_at    = -1;
            drop_exp   = 0;
            prev_stall = 1'b0;
        end
        fifo_data = pend_pop ? pend_data : 16'($urandom);
        pend_pop  = 1'b0;
        rst    = rst_req;
        enable = en_req;
        alt    = ~alt;
        case (ready_mode)
            0:       win_ready = 1'b1;
            1:       win_ready = alt;
            2:       win_ready = 1'($urandom_range(0, 1));
            default: win_ready = 1'b0;
        endcase
        if (rst_req) win_ready = 1'b0;
        fifo_empty = (fifo_q.size() == 0);
        if (cyc == drop_at && drop_exp < 65535) drop_exp++;

        check("fifo_read_en", fifo_read_en, can_pop);
        if (fifo_read_en && fifo_q.size() != 0) begin
            rd_cyc    = cyc;
            ev        = fifo_q.pop_front();
            pend_pop  = 1'b1;
            pend_data = ev;
            if (!expand(ev)) drop_at = cyc + 2;
        end

        busy_exp = (cyc == rd_cyc) || (cyc == rd_cyc + 1) || (exp_q.size() != 0);
        check("busy", busy, busy_exp);
        check("win_valid", win_valid, (exp_q.size() != 0) && (cyc >= rd_cyc + 2));

        if (prev_stall) begin
            check("stall_coord", win_coord, prev_coord);
            check("stall_kx", win_kx, prev_kx);
            check("stall_ky", win_ky, prev_ky);
            check("stall_last", win_last, prev_last);
        end
        if (win_valid && exp_q.size() != 0) begin
            h = exp_q[0];
            check("win_coord", win_coord, {h.x, h.y});
            check("win_kx", win_kx, h.kx);
            check("win_ky", win_ky, h.ky);
            check("win_last", win_last, h.last);
            if (win_ready) void'(exp_q.pop_front());
        end
        prev_stall = win_valid && !win_ready;
        prev_coord = win_coord;
        prev_kx    = win_kx;
        prev_ky    = win_ky;
        prev_last  = win_last;
`ifdef CONV_DROP_COUNT_EN
        check("dropped_count", dropped_count, drop_exp);
`endif
        can_pop = !busy_exp && enable && !fifo_empty && !rst;
    endtask

    // Run until the FIFO model is empty and the sequencer is idle.
    task automatic drain(input int budget);
        int n = 0;
        step();
        while ((fifo_q.size() != 0 || busy_exp || exp_q.size() != 0) && n < budget) begin
            step();
            n++;
        end
        check("drain_in_budget", n < budget, 1'b1);
    endtask

    initial begin
        rst        = 1'b1;
        enable     = 1'b0;
        fifo_empty = 1'b1;
        fifo_data  = '0;
        win_ready  = 1'b0;

        // Reset state
        rst_req    = 1'b1;
        ready_mode = 3;
        step();
        step();
        check("rst_fifo_read_en", fifo_read_en, 1'b0);
        check("rst_win_valid", win_valid, 1'b0);
        check("rst_win_last", win_last, 1'b0);
        check("rst_win_coord", win_coord, 16'h0000);
        check("rst_win_kx", win_kx, 2'd0);
        check("rst_win_ky", win_ky, 2'd0);
        check("rst_busy", busy, 1'b0);
        rst_req = 1'b0;
        step();

        // enable low with a pending event: no pop; then (10,10) full window
        ready_mode = 0;
        fifo_q.push_back({8'd10, 8'd10});
        for (int i = 0; i < 10; i++) step();
        check("no_pop_disabled", fifo_q.size(), 1);
        en_req = 1'b1;
        drain(100);

        // Corner events, back-to-back
        fifo_q.push_back({8'd0, 8'd0});
        fifo_q.push_back({8'd31, 8'd31});
        drain(100);

        // Alternating ready
        ready_mode = 1;
        fifo_q.push_back({8'd5, 8'd5});
        drain(100);

        // Out-of-bounds event followed by a valid one
        ready_mode = 0;
        fifo_q.push_back({8'd32, 8'd5});
        fifo_q.push_back({8'd3, 8'd3});
        drain(100);

        // Reset during the 4th beat of (10,10), then (2,2)
        fifo_q.push_back({8'd10, 8'd10});
        for (int i = 0; i < 20 && exp_q.size() != 6; i++) step();
        check("reached_4th_beat", exp_q.size(), 6);
        rst_req = 1'b1;
        step();
        rst_req = 1'b0;
        step();
        check("post_rst_valid", win_valid, 1'b0);
        check("post_rst_busy", busy, 1'b0);
        fifo_q.push_back({8'd2, 8'd2});
        drain(100);

        // Random events, random ready and enable
        ready_mode = 2;
        for (int i = 0; i < 40; i++) begin
            logic [7:0] rx, ry;
            rx = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(32, 255)) : 8'($urandom_range(0, 31));
            ry = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(32, 255)) : 8'($urandom_range(0, 31));
            fifo_q.push_back({rx, ry});
        end
        for (int i = 0; i < 3000 && (fifo_q.size() != 0 || busy_exp); i++) begin
            en_req = ($urandom_range(0, 7) != 0);
            step();
        end
        en_req = 1'b1;
        drain(2000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
